// File: rtl/sc_mnist_pkg.sv
// Shared definitions for the stochastic-computing MNIST datapath: network sizes,
// window exponent, decoder state encoding and index-width helper.
package sc_mnist_pkg;

  localparam int N0 = 784;
  localparam int N1 = 128;
  localparam int N2 = 10;
  localparam int L_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCAN  = 2'd2,
    HOLD  = 2'd3
  } dec_state_e;

  function automatic int idx_width(input int n_classes);
    return (n_classes <= 2) ? 1 : $clog2(n_classes);
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Per-class ones counter for one output bitstream; saturates at 2^L so a
// window can never wrap the count.
module sc_ones_counter #(
  parameter int L     = 8,
  parameter int CNT_W = L + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [CNT_W-1:0] SAT = CNT_W'(2 ** L);

  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (en_i && bit_i && (count_q != SAT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/sc_mnist_argmax_decoder.sv
// Output stage: counts ones per class over a 2^L window, scans the counts one
// class per cycle for the argmax, and holds the result behind valid/ready.
module sc_mnist_argmax_decoder
  import sc_mnist_pkg::*;
#(
  parameter int N2    = sc_mnist_pkg::N2,
  parameter int L     = sc_mnist_pkg::L_DEFAULT,
  parameter int CNT_W = L + 1,
  parameter int IDX_W = idx_width(N2)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [N2-1:0]         din,
  output logic                  busy,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_W-1:0]      class_idx,
  output logic [CNT_W-1:0]      class_count,
  output logic [N2*CNT_W-1:0]   counts_flat
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N2 - 1);

  dec_state_e       state_q;
  logic [L-1:0]     win_q;
  logic [IDX_W-1:0] scan_q;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;
  logic [CNT_W-1:0] best_cnt_q, best_cnt_d;
  logic [IDX_W-1:0] class_idx_q;
  logic [CNT_W-1:0] class_cnt_q;
  logic             out_valid_q;
  logic             busy_q;

  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_w [N2];
  logic [CNT_W-1:0] cur_cnt;

  assign cnt_clr = (state_q == IDLE) && start;
  assign cnt_en  = (state_q == ACCUM);

  for (genvar i = 0; i < N2; i++) begin : g_cnt
    sc_ones_counter #(
      .L     (L),
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .clr_i   (cnt_clr),
      .en_i    (cnt_en),
      .bit_i   (din[i]),
      .count_o (cnt_w[i])
    );
    assign counts_flat[i*CNT_W +: CNT_W] = cnt_w[i];
  end

  // Candidate for this scan step; strict '>' keeps the lowest index on ties.
  always_comb begin
    cur_cnt = '0;
    for (int i = 0; i < N2; i++) begin
      if (scan_q == IDX_W'(i)) cur_cnt = cnt_w[i];
    end
    best_idx_d = best_idx_q;
    best_cnt_d = best_cnt_q;
    if ((scan_q == '0) || (cur_cnt > best_cnt_q)) begin
      best_idx_d = scan_q;
      best_cnt_d = cur_cnt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      win_q       <= '0;
      scan_q      <= '0;
      best_idx_q  <= '0;
      best_cnt_q  <= '0;
      class_idx_q <= '0;
      class_cnt_q <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            win_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          win_q <= win_q + 1'b1;
          if (win_q == '1) begin
            scan_q  <= '0;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          best_idx_q <= best_idx_d;
          best_cnt_q <= best_cnt_d;
          if (scan_q == LAST) begin
            class_idx_q <= best_idx_d;
            class_cnt_q <= best_cnt_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= HOLD;
          end else begin
            scan_q <= scan_q + 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign out_valid   = out_valid_q;
  assign class_idx   = class_idx_q;
  assign class_count = class_cnt_q;

endmodule

// File: doc/sc_mnist_argmax_decoder.md
Name: sc_mnist_argmax_decoder

Overview:
Downstream stage of the stochastic-computing MNIST network. It consumes the N2 output-layer bitstreams and counts the ones on each stream over a fixed window of 2^L clocks. It then scans the counts sequentially to find the winning class, and presents the class index and its count through a valid/ready handshake. Only this block turns stochastic outputs back into a binary result.

Parameters:
N2, 10, number of output-layer bitstreams (classes)
L, 8, log2 of window length; window = 2^L samples
CNT_W, L+1, per-class counter width; must hold 2^L
IDX_W, 4, class index width; 2^IDX_W >= N2

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a classification window
din  in  N2  output-layer bitstreams, one bit per class per clock
busy  out  1  high in ACCUM and SCAN
out_valid  out  1  result available
out_ready  in  1  consumer accepts result when high with out_valid
class_idx  out  IDX_W  winning class index
class_count  out  CNT_W  ones-count of winning class
counts_flat  out  N2*CNT_W  all per-class counts, class i at bits [i*CNT_W +: CNT_W], for debug

Behaviour:
- Reset (reset low, async):
  - state=IDLE; all counters, window counter, scan index and best registers cleared.
  - busy=0, out_valid=0, class_idx=0, class_count=0, counts_flat=0.
  - Reset mid-window or mid-scan aborts with no output.
- FSM states: IDLE, ACCUM, SCAN, HOLD.
- IDLE:
  - start=1 clears all class counters and the window counter, then moves to ACCUM.
  - start=0 stays in IDLE.
  - din is ignored.
- ACCUM:
  - Each cycle, count[i] += din[i] for every i.
  - Window counter increments each cycle; after exactly 2^L sampled cycles, moves to SCAN.
  - start is ignored.
  - Counter cannot overflow (max 2^L fits in CNT_W). The implementation still saturates at 2^L as a guard.
- SCAN:
  - One class per cycle, i=0..N2-1; N2 cycles total.
  - best is initialised from class 0.
  - Class i replaces best only if count[i] > best_count (strict). Ties therefore resolve to the lowest index.
  - After class N2-1, latches class_idx and class_count, then moves to HOLD.
- HOLD:
  - out_valid=1; class_idx, class_count and counts_flat are held stable.
  - out_valid && out_ready in a cycle completes the transfer; out_valid drops next cycle and state returns to IDLE.
  - start during HOLD is ignored, including in the handshake cycle.
  - No result is ever dropped or overwritten while out_valid=1.
- Timing, with start high in cycle 0:
  - din is sampled in cycles 1..2^L.
  - SCAN occupies cycles 2^L+1..2^L+N2.
  - out_valid rises in cycle 2^L+N2+1 (267 with defaults).
  - If out_ready is held high, the earliest next start is one cycle after the handshake.
- counts_flat:
  - Updates live during ACCUM and is frozen in SCAN and HOLD.
  - Cleared at the next start.
- busy=1 exactly in ACCUM and SCAN.

Decomposition:
- Package sc_mnist_pkg holds:
  - typedef enum for decoder state {IDLE, ACCUM, SCAN, HOLD};
  - network size constants (N0=784, N1=128, N2=10);
  - default window exponent L=8;
  - a function computing index width from class count.
- Sub-module sc_ones_counter: one per class. It has CNT_W saturating counter, clear, enable and bit inputs, and is instantiated N2 times in a generate loop.
- The argmax scan and FSM stay in the top module.

Test Plan:
- din[3]=1 constantly, all other bits 0, start pulse -> out_valid at cycle 267; class_idx=3, class_count=256, every other count 0.
- din[5] toggles 1,0,1,0…; din[1] is 1 every 4th cycle; rest 0 -> class_idx=5, class_count=128, count[1]=64.
- din[2] and din[7] constant 1 (tie at 256) -> class_idx=2, class_count=256. Also all-zero input -> class_idx=0, class_count=0.
- Result ready, out_ready held low 5 cycles with start pulsed during HOLD -> out_valid stays 1, outputs unchanged, start ignored. Handshake on cycle 6 -> out_valid=0 next cycle, state IDLE.
- reset asserted low at cycle 100 of ACCUM -> outputs immediately 0, busy=0. After release, a fresh start with din[9]=1 -> class_idx=9, count 256, with no residue from the aborted window.
- Back-to-back: out_ready tied high, second start one cycle after the handshake with different stimulus -> second result is correct and independent of the first.
